// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: MEM-stage responder that drives the on-board UART through its
// rdn/wrn strobe protocol over the low byte of the shared Ram1 data bus.
// Single-word byte writes, data reads and status reads are supported; Ram1 is
// held disabled while this block owns the bus.
// Optional build macro: UART_RXBUF_EN adds a 4-entry receive FIFO that drains
// the UART autonomously while no request is pending.
module uart_bus_ctrl #(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic        stat_i,
  input  logic [7:0]  wdata_i,
  output logic [15:0] rdata_o,
  output logic        ack_o,
  output logic        busy_o,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre,
  output logic        wrn,
  output logic        rdn,
  output logic [7:0]  bus_data_o,
  output logic        bus_oe_o,
  input  logic [7:0]  bus_data_i,
  output logic        ram1_dis_o
);

  localparam int MAX_CYC = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_TBRE,
    S_WR_TSRE,
    S_RD_WAIT,
    S_RD_PULSE,
    S_DONE
  } state_e;

  // Synchroniser chains for the asynchronous UART status pins
  logic [1:0] dr_ff_q, dr_ff_d;
  logic [1:0] tbre_ff_q, tbre_ff_d;
  logic [1:0] tsre_ff_q, tsre_ff_d;
  logic       dr_sync, tbre_sync, tsre_sync;
  logic       rx_avail;

  // FSM state and registered outputs
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrn_q, wrn_d;
  logic             rdn_q, rdn_d;
  logic             bus_oe_q, bus_oe_d;
  logic             ram1_dis_q, ram1_dis_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [7:0]       bus_data_q, bus_data_d;

`ifdef UART_RXBUF_EN
  logic [7:0] fifo_mem_q [4];
  logic       fifo_push, fifo_pop;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] fifo_cnt_q, fifo_cnt_d;
  logic       auto_q, auto_d;
`endif

  // Next value of each synchroniser chain: shift the raw pin in at the bottom
  always_comb begin
    dr_ff_d   = {dr_ff_q[0], data_ready};
    tbre_ff_d = {tbre_ff_q[0], tbre};
    tsre_ff_d = {tsre_ff_q[0], tsre};
  end

  // Two-flop synchronisers, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dr_ff_q   <= 2'b00;
      tbre_ff_q <= 2'b00;
      tsre_ff_q <= 2'b00;
    end else begin
      dr_ff_q   <= dr_ff_d;
      tbre_ff_q <= tbre_ff_d;
      tsre_ff_q <= tsre_ff_d;
    end
  end

  assign dr_sync   = dr_ff_q[1];
  assign tbre_sync = tbre_ff_q[1];
  assign tsre_sync = tsre_ff_q[1];

`ifdef UART_RXBUF_EN
  assign rx_avail = dr_sync | (fifo_cnt_q != 3'd0);
`else
  assign rx_avail = dr_sync;
`endif

  // Next-state and next-output logic; outputs are computed for the state being entered
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wrn_d      = wrn_q;
    rdn_d      = rdn_q;
    bus_oe_d   = bus_oe_q;
    ram1_dis_d = ram1_dis_q;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    bus_data_d = bus_data_q;
`ifdef UART_RXBUF_EN
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    auto_d     = auto_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (we_i) begin
            bus_data_d = wdata_i;
            state_d    = S_WR_SETUP;
            cnt_d      = SETUP_LOAD;
            bus_oe_d   = 1'b1;
            ram1_dis_d = 1'b1;
          end else if (stat_i) begin
            rdata_d = {14'b0, rx_avail, tbre_sync & tsre_sync};
            state_d = S_DONE;
            ack_d   = 1'b1;
          end else begin
`ifdef UART_RXBUF_EN
            if (fifo_cnt_q != 3'd0) begin
              // Buffered byte: answer without touching the bus
              rdata_d  = {8'h00, fifo_mem_q[rd_ptr_q]};
              fifo_pop = 1'b1;
              state_d  = S_DONE;
              ack_d    = 1'b1;
            end else begin
              state_d    = S_RD_WAIT;
              ram1_dis_d = 1'b1;
            end
`else
            state_d    = S_RD_WAIT;
            ram1_dis_d = 1'b1;
`endif
          end
        end
`ifdef UART_RXBUF_EN
        else if (dr_sync && (fifo_cnt_q != 3'd4)) begin
          // Nobody is asking: drain the UART into the FIFO
          state_d    = S_RD_PULSE;
          cnt_d      = PULSE_LOAD;
          rdn_d      = 1'b0;
          ram1_dis_d = 1'b1;
          auto_d     = 1'b1;
        end
`endif
      end

      S_WR_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_WR_PULSE;
          cnt_d   = PULSE_LOAD;
          wrn_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d  = S_WR_TBRE;
          wrn_d    = 1'b1;
          bus_oe_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_WR_TBRE: begin
        if (tbre_sync) begin
          state_d = S_WR_TSRE;
        end
      end

      S_WR_TSRE: begin
        if (tsre_sync) begin
          state_d    = S_DONE;
          ack_d      = 1'b1;
          ram1_dis_d = 1'b0;
        end
      end

      S_RD_WAIT: begin
        if (dr_sync) begin
          state_d = S_RD_PULSE;
          cnt_d   = PULSE_LOAD;
          rdn_d   = 1'b0;
        end
      end

      S_RD_PULSE: begin
        if (cnt_q == '0) begin
          rdn_d      = 1'b1;
          ram1_dis_d = 1'b0;
`ifdef UART_RXBUF_EN
          if (auto_q) begin
            fifo_push = 1'b1;
            auto_d    = 1'b0;
            state_d   = S_IDLE;
          end else begin
            rdata_d = {8'h00, bus_data_i};
            state_d = S_DONE;
            ack_d   = 1'b1;
          end
`else
          rdata_d = {8'h00, bus_data_i};
          state_d = S_DONE;
          ack_d   = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_DONE: begin
        state_d    = S_IDLE;
        wrn_d      = 1'b1;
        rdn_d      = 1'b1;
        bus_oe_d   = 1'b0;
        ram1_dis_d = 1'b0;
      end

      default: begin
        state_d    = S_IDLE;
        wrn_d      = 1'b1;
        rdn_d      = 1'b1;
        bus_oe_d   = 1'b0;
        ram1_dis_d = 1'b0;
      end
    endcase

`ifdef UART_RXBUF_EN
    // Push and pop never coincide: push happens only in RD_PULSE, pop only in IDLE
    if (fifo_push) begin
      wr_ptr_d   = wr_ptr_q + 2'd1;
      fifo_cnt_d = fifo_cnt_q + 3'd1;
    end
    if (fifo_pop) begin
      rd_ptr_d   = rd_ptr_q + 2'd1;
      fifo_cnt_d = fifo_cnt_q - 3'd1;
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  // FSM register: state, counter and every registered output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wrn_q      <= 1'b1;
      rdn_q      <= 1'b1;
      bus_oe_q   <= 1'b0;
      ram1_dis_q <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= 16'h0000;
      bus_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wrn_q      <= wrn_d;
      rdn_q      <= rdn_d;
      bus_oe_q   <= bus_oe_d;
      ram1_dis_q <= ram1_dis_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      bus_data_q <= bus_data_d;
    end
  end

`ifdef UART_RXBUF_EN
  // FIFO bookkeeping; reset empties the buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      fifo_cnt_q <= 3'd0;
      auto_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      auto_q     <= auto_d;
    end
  end

  // FIFO storage captures the bus byte at the end of an autonomous read pulse
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem_q[wr_ptr_q] <= bus_data_i;
    end
  end
`endif

  assign wrn        = wrn_q;
  assign rdn        = rdn_q;
  assign bus_oe_o   = bus_oe_q;
  assign ram1_dis_o = ram1_dis_q;
  assign ack_o      = ack_q;
  assign busy_o     = busy_q;
  assign rdata_o    = rdata_q;
  assign bus_data_o = bus_data_q;

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Testbench for uart_bus_ctrl: directed transactions against a small UART model,
// with a per-cycle protocol/scoreboard check folded into the clock tick.
module tb_uart_bus_ctrl;

  localparam int S = 1;
  localparam int P = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i, stat_i;
  logic [7:0]  wdata_i;
  logic [15:0] rdata_o;
  logic        ack_o, busy_o;
  logic        data_ready, tbre, tsre;
  logic        wrn, rdn;
  logic [7:0]  bus_data_o;
  logic        bus_oe_o;
  logic [7:0]  bus_data_i;
  logic        ram1_dis_o;

  uart_bus_ctrl #(.SETUP_CYCLES(S), .PULSE_CYCLES(P)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .stat_i(stat_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o), .busy_o(busy_o),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .wrn(wrn), .rdn(rdn),
    .bus_data_o(bus_data_o), .bus_oe_o(bus_oe_o), .bus_data_i(bus_data_i),
    .ram1_dis_o(ram1_dis_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [15:0] data;
  } exp_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_wbyte = 8'h00;
  int          wrn_run = 0, rdn_run = 0, oe_run = 0;
  int          n_wr_pulses = 0, n_rd_pulses = 0, last_wrn_rise = -1;
  bit          prev_ack = 1'b0, rd_taken = 1'b0;
  int          sched_tbre = -1, sched_tsre = -1, sched_rx = -1;
  logic [7:0]  sched_rx_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART model: data_ready reflects a pending byte not yet taken by an rdn pulse
  task automatic set_uart();
    data_ready = (rx_q.size() != 0) && !rd_taken;
    bus_data_i = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endtask

  // One clock: sample at the falling edge, check protocol rules, update the UART model
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!wrn) begin
      wrn_run++;
      check("wrn_needs_oe", bus_oe_o, 1'b1);
    end else if (wrn_run != 0) begin
      check("wrn_width", wrn_run, P);
      wrn_run = 0;
      n_wr_pulses++;
      last_wrn_rise = cyc;
    end
    if (!rdn) begin
      rdn_run++;
      check("rdn_exclusive", {bus_oe_o, wrn}, 2'b01);
    end else if (rdn_run != 0) begin
      check("rdn_width", rdn_run, P);
      rdn_run = 0;
      n_rd_pulses++;
    end
    if (bus_oe_o) begin
      oe_run++;
      check("bus_data", bus_data_o, exp_wbyte);
    end else if (oe_run != 0) begin
      check("oe_width", oe_run, S + P);
      oe_run = 0;
    end
    if (bus_oe_o || !wrn || !rdn) check("ram1_dis_owned", {ram1_dis_o, busy_o}, 2'b11);
    if (ack_o) begin
      check("ack_single", prev_ack, 1'b0);
      check("busy_in_done", busy_o, 1'b1);
      if (exp_q.size() == 0) check("ack_expected", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        if (e.is_read) check("rdata", rdata_o, e.data);
      end
    end
    prev_ack = ack_o;
    if (!rdn) rd_taken = 1'b1;
    else if (rd_taken) begin
      rd_taken = 1'b0;
      if (rx_q.size() != 0) void'(rx_q.pop_front());
    end
    if (cyc == sched_tbre) tbre = 1'b1;
    if (cyc == sched_tsre) tsre = 1'b1;
    if (cyc == sched_rx) rx_q.push_back(sched_rx_byte);
    set_uart();
  endtask

  task automatic wait_ack(input int budget, output int ack_cyc);
    ack_cyc = -1;
    for (int i = 0; i < budget && ack_cyc < 0; i++) begin
      tick();
      if (ack_o) ack_cyc = cyc;
    end
    if (ack_cyc < 0) check("ack_timeout", ack_o, 1'b1);
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Byte write; tbre/tsre rise tb_dly/ts_dly cycles after wrn returns high (0 = already high)
  task automatic do_write(input logic [7:0] b, input int tb_dly, input int ts_dly,
                          input bit keep, output int lat);
    int a, r, tb, ts, ack_c;
    exp_wbyte = b; wdata_i = b; we_i = 1'b1; stat_i = 1'b0;
    if (tb_dly > 0) tbre = 1'b0;
    if (ts_dly > 0) tsre = 1'b0;
    req_i = 1'b1;
    a = cyc;
    exp_q.push_back('{1'b0, 16'h0000});
    r = a + 1 + S + P;
    sched_tbre = (tb_dly > 0) ? r + tb_dly : -1;
    sched_tsre = (ts_dly > 0) ? r + ts_dly : -1;
    tb = imax(r, (tb_dly > 0) ? r + tb_dly + 2 : 0);
    ts = imax(tb + 1, (ts_dly > 0) ? r + ts_dly + 2 : 0);
    wait_ack(100, ack_c);
    check("wr_ack_cycle", ack_c, ts + 1);
    check("wr_rise_cycle", last_wrn_rise, r);
    check("wr_ram1_free_at_ack", ram1_dis_o, 1'b0);
    if (!keep) req_i = 1'b0;
    lat = ack_c - a;
    tick();
    check("idle_after_ack", {busy_o, ack_o}, 2'b00);
  endtask

  // Data read; the UART byte appears dly cycles after the request (<0 = already there)
  task automatic do_read(input logic [7:0] b, input int dly, input bit fifo_hit, output int lat);
    int a, exp_c, ack_c;
    we_i = 1'b0; stat_i = 1'b0; req_i = 1'b1;
    a = cyc;
    exp_q.push_back('{1'b1, {8'h00, b}});
    if (!fifo_hit && dly == 0) begin rx_q.push_back(b); set_uart(); end
    else if (!fifo_hit && dly > 0) begin sched_rx = a + dly; sched_rx_byte = b; end
    if (fifo_hit) exp_c = a + 1;
    else exp_c = imax(a + 1, (dly >= 0) ? a + dly + 2 : 0) + P + 1;
    wait_ack(100, ack_c);
    check("rd_ack_cycle", ack_c, exp_c);
    req_i = 1'b0;
    lat = ack_c - a;
    tick();
    check("idle_after_ack", {busy_o, ack_o, rdn}, 3'b001);
  endtask

  task automatic do_status(input logic [15:0] v, output int lat);
    int a, ack_c;
    we_i = 1'b0; stat_i = 1'b1; req_i = 1'b1;
    a = cyc;
    exp_q.push_back('{1'b1, v});
    wait_ack(20, ack_c);
    req_i = 1'b0; stat_i = 1'b0;
    lat = ack_c - a;
    tick();
    check("idle_after_status", busy_o, 1'b0);
  endtask

  initial begin
    int lat, a, base;
    rst = 1'b0; req_i = 1'b0; we_i = 1'b0; stat_i = 1'b0; wdata_i = 8'h00;
    tbre = 1'b1; tsre = 1'b1;
    set_uart();
    repeat (3) tick();
    check("rst_wrn", wrn, 1'b1);
    check("rst_rdn", rdn, 1'b1);
    check("rst_oe", bus_oe_o, 1'b0);
    check("rst_ram1", ram1_dis_o, 1'b0);
    check("rst_ack", ack_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_rdata", rdata_o, 16'h0000);
    check("rst_bus_data", bus_data_o, 8'h00);
    rst = 1'b1;
    repeat (3) tick();

    // Write with slow TX handshake
    base = n_wr_pulses;
    do_write(8'h5A, 3, 6, 1'b0, lat);
    check("wr_5a_latency", lat, 13);
    check("wr_5a_pulses", n_wr_pulses - base, 1);
    repeat (2) tick();

    // Read with data_ready arriving late
    do_read(8'hC3, 10, 1'b0, lat);
    check("rd_c3_latency", lat, 15);
    check("rd_c3_rdata_hold", rdata_o, 16'h00C3);
    repeat (2) tick();

`ifndef UART_RXBUF_EN
    // Status: data_ready=1, tbre=1, tsre=0
    tsre = 1'b0;
    rx_q.push_back(8'hEE); set_uart();
    repeat (3) tick();
    do_status(16'h0002, lat);
    check("stat_latency", lat, 1);
    rx_q.delete(); tsre = 1'b1; set_uart();
    repeat (4) tick();
`endif

    // Reset during the write pulse
    exp_wbyte = 8'hA5; wdata_i = 8'hA5; we_i = 1'b1; req_i = 1'b1;
    a = cyc;
    while (cyc < a + 2) tick();
    check("pre_rst_wrn_low", wrn, 1'b0);
    rst = 1'b0;
    #1;
    check("async_rst_wrn", wrn, 1'b1);
    check("async_rst_oe", bus_oe_o, 1'b0);
    check("async_rst_busy", busy_o, 1'b0);
    check("async_rst_ram1", ram1_dis_o, 1'b0);
    wrn_run = 0; oe_run = 0; rdn_run = 0;
    req_i = 1'b0; we_i = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    do_read(8'h3C, 2, 1'b0, lat);
    check("rd_after_rst_latency", lat, 7);
    repeat (2) tick();

    // Back-to-back writes with req_i held high
    base = n_wr_pulses;
    do_write(8'h01, 0, 0, 1'b1, lat);
    check("b2b_first_latency", lat, 6);
    do_write(8'h02, 0, 0, 1'b0, lat);
    check("b2b_second_latency", lat, 6);
    check("b2b_pulses", n_wr_pulses - base, 2);
    repeat (2) tick();

`ifdef UART_RXBUF_EN
    // Autonomous buffering of five unrequested bytes
    base = n_rd_pulses;
    for (int k = 0; k < 5; k++) rx_q.push_back(8'h10 + 8'(k));
    set_uart();
    repeat (60) tick();
    check("fifo_auto_reads", n_rd_pulses - base, 4);
    check("fifo_fifth_pending", rx_q.size(), 1);
    do_status(16'h0003, lat);
    check("fifo_stat_latency", lat, 1);
    for (int k = 0; k < 4; k++) begin
      base = n_rd_pulses;
      do_read(8'h10 + 8'(k), -1, 1'b1, lat);
      check("fifo_pop_latency", lat, 1);
      check("fifo_pop_no_bus", n_rd_pulses - base, 0);
    end
    do_read(8'h14, -1, 1'b0, lat);
    check("fifo_fifth_latency", lat, 4);
    repeat (2) tick();
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
